// File: rtl/video_timing_gen.sv
// Raster timing source for the scandoubler: pixel-enable divider plus
// horizontal/vertical counters with registered sync, blank and start strobes.
module video_timing_gen #(
  parameter int CE_DIV   = 4,
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 26
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic       enable,
  output logic       ce_pix,
  output logic       hs,
  output logic       vs,
  output logic       hb,
  output logic       vb,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CE_DIV < 2) ? 1 : $clog2(CE_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_BLANK   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_BLANK   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CE_DIV < 2) begin : g_bad_div
    $error("video_timing_gen: CE_DIV must be >= 2");
  end
  if (H_BP < 1 || V_BP < 1) begin : g_bad_bp
    $error("video_timing_gen: H_BP and V_BP must be >= 1");
  end

  logic [DIV_W-1:0] div;
  logic             step;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;

  assign step = enable && (div == DIV_LAST);

  always_comb begin
    h_nxt = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
    v_nxt = vcnt;
    if (hcnt == H_LAST) begin
      v_nxt = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end
  end

  // Reset parks the raster on the last pixel so the first step lands on (0,0).
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      div         <= '0;
      hcnt        <= H_LAST;
      vcnt        <= V_LAST;
      hb          <= 1'b1;
      vb          <= 1'b1;
      hs          <= 1'b0;
      vs          <= 1'b0;
      ce_pix      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ce_pix      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end
      if (step) begin
        ce_pix      <= 1'b1;
        hcnt        <= h_nxt;
        vcnt        <= v_nxt;
        hb          <= (h_nxt >= H_BLANK);
        hs          <= (h_nxt >= H_SYNC_LO) && (h_nxt < H_SYNC_HI);
        vb          <= (v_nxt >= V_BLANK);
        vs          <= (v_nxt >= V_SYNC_LO) && (v_nxt < V_SYNC_HI);
        line_start  <= (h_nxt == 10'd0);
        frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster checked cycle-by-cycle against an
// arithmetic pixel-index model, plus default-size line/frame measurements.
module tb_video_timing_gen;

  localparam int CE  = 2;
  localparam int HA  = 4, HFP = 1, HSW = 2, HBP = 1;
  localparam int VA  = 3, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;

  logic       clk_vid = 1'b0;
  logic       reset   = 1'b0;
  logic       enable  = 1'b0;
  logic       ce_pix, hs, vs, hb, vb, line_start, frame_start;
  logic [9:0] hcnt, vcnt;

  logic       rst_def = 1'b0;
  logic       en_on   = 1'b1;
  logic       d_ce, d_hs, d_vs, d_hb, d_vb, d_ls, d_fs;
  logic [9:0] d_hcnt, d_vcnt;

  logic       rst_dv  = 1'b0;
  logic       v_ce, v_hs, v_vs, v_hb, v_vb, v_ls, v_fs;
  logic [9:0] v_hcnt, v_vcnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m_en_edges = 0;
  int m_steps    = 0;
  logic m_ce     = 1'b0;

  logic [26:0] act;
  assign act = {ce_pix, line_start, frame_start, hs, vs, hb, vb, hcnt, vcnt};

  localparam logic [26:0] RESET_VEC  = {7'b0000011, 10'd7, 10'd5};
  localparam logic [26:0] FIRST_VEC  = {7'b1110000, 10'd0, 10'd0};

  video_timing_gen #(
    .CE_DIV(CE), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk_vid(clk_vid), .reset(reset), .enable(enable), .ce_pix(ce_pix),
    .hs(hs), .vs(vs), .hb(hb), .vb(vb), .hcnt(hcnt), .vcnt(vcnt),
    .line_start(line_start), .frame_start(frame_start)
  );

  video_timing_gen u_def (
    .clk_vid(clk_vid), .reset(rst_def), .enable(en_on), .ce_pix(d_ce),
    .hs(d_hs), .vs(d_vs), .hb(d_hb), .vb(d_vb), .hcnt(d_hcnt), .vcnt(d_vcnt),
    .line_start(d_ls), .frame_start(d_fs)
  );

  video_timing_gen #(
    .CE_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) u_dv (
    .clk_vid(clk_vid), .reset(rst_dv), .enable(en_on), .ce_pix(v_ce),
    .hs(v_hs), .vs(v_vs), .hb(v_hb), .vb(v_vb), .hcnt(v_hcnt), .vcnt(v_vcnt),
    .line_start(v_ls), .frame_start(v_fs)
  );

  always #5 clk_vid = ~clk_vid;

  // Pixel index s (steps since reset) maps to position s-1 in raster order;
  // s=0 is the parked last pixel.
  function automatic logic [26:0] exp_vec(input int s, input logic ce);
    int p, h, v;
    logic e_hs, e_vs, e_hb, e_vb;
    p = s + HT * VT - 1;
    h = p % HT;
    v = (p / HT) % VT;
    e_hb = (h >= HA);
    e_hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
    e_vb = (v >= VA);
    e_vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
    return {ce, ce && (h == 0), ce && (h == 0) && (v == 0),
            e_hs, e_vs, e_hb, e_vb, 10'(h), 10'(v)};
  endfunction

  task automatic model_reset();
    m_en_edges = 0;
    m_steps    = 0;
    m_ce       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_vid);
    cyc++;
    m_ce = 1'b0;
    if (!reset && enable) begin
      m_en_edges++;
      if (m_en_edges % CE == 0) begin
        m_steps++;
        m_ce = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    #1 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (act !== RESET_VEC) $display("FAIL reset_state: got %h expected %h", act, RESET_VEC);
    else n_pass++;
  endtask

  task automatic test_first_step();
    enable = 1'b1;
    @(negedge clk_vid);
    reset = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (act !== exp_vec(m_steps, m_ce)) $display("FAIL first_edge1: got %h expected %h", act, exp_vec(m_steps, m_ce));
    else n_pass++;
    tick();
    n_checks++;
    if (act !== FIRST_VEC) $display("FAIL first_pixel: got %h expected %h", act, FIRST_VEC);
    else n_pass++;
  endtask

  task automatic test_line();
    int last_ls;
    logic prev_ce;
    last_ls = cyc;
    prev_ce = ce_pix;
    for (int i = 0; i < 2 * HT * CE; i++) begin
      tick();
      n_checks++;
      if (act !== exp_vec(m_steps, m_ce)) $display("FAIL line_vec: got %h expected %h", act, exp_vec(m_steps, m_ce));
      else n_pass++;
      if (ce_pix && prev_ce) begin
        n_checks++;
        $display("FAIL line_ce_gap: got back-to-back ce_pix expected gap at cycle %0d", cyc);
      end
      if (line_start) begin
        n_checks++;
        if (cyc - last_ls !== HT * CE) $display("FAIL line_period: got %0d expected %0d", cyc - last_ls, HT * CE);
        else n_pass++;
        last_ls = cyc;
      end
      prev_ce = ce_pix;
    end
  endtask

  task automatic test_frames();
    int last_fs;
    logic prev_vs, prev_vb;
    last_fs = -1;
    prev_vs = vs;
    prev_vb = vb;
    for (int i = 0; i < 2 * HT * VT * CE + 4; i++) begin
      tick();
      n_checks++;
      if (act !== exp_vec(m_steps, m_ce)) $display("FAIL frame_vec: got %h expected %h", act, exp_vec(m_steps, m_ce));
      else n_pass++;
      if (vs !== prev_vs || vb !== prev_vb) begin
        n_checks++;
        if (!(ce_pix && hcnt == 10'd0)) $display("FAIL vert_edge_hcnt: got hcnt %0d ce %b expected hcnt 0 ce 1", hcnt, ce_pix);
        else n_pass++;
      end
      if (frame_start) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (cyc - last_fs !== HT * VT * CE) $display("FAIL frame_period: got %0d expected %0d", cyc - last_fs, HT * VT * CE);
          else n_pass++;
        end
        last_fs = cyc;
      end
      prev_vs = vs;
      prev_vb = vb;
    end
  endtask

  task automatic test_enable_hold();
    int waited;
    logic [19:0] snap;
    logic [9:0] snap_v;
    waited = 0;
    while (!(ce_pix && hcnt == 10'd2) && waited < 64) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited >= 64) begin
      $display("FAIL hold_find: got timeout expected hcnt=2 pixel");
      return;
    end
    n_pass++;
    snap   = act[19:0] | 20'd0;
    snap   = {act[23:20], act[19:10], 6'd0};
    snap_v = vcnt;
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if ({ce_pix, line_start, frame_start} !== 3'b000 || {hs, vs, hb, vb, hcnt} !== snap[19:6] || vcnt !== snap_v)
        $display("FAIL hold_frozen: got %h expected levels %h vcnt %0d strobes 0", act, snap[19:6], snap_v);
      else n_pass++;
    end
    enable = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!ce_pix && waited < 8);
    n_checks++;
    if (waited !== CE) $display("FAIL hold_phase: got %0d cycles expected %0d", waited, CE);
    else n_pass++;
    n_checks++;
    if (hcnt !== 10'd3 || vcnt !== snap_v) $display("FAIL hold_resume: got h=%0d v=%0d expected h=3 v=%0d", hcnt, vcnt, snap_v);
    else n_pass++;
    n_checks++;
    if (act !== exp_vec(m_steps, m_ce)) $display("FAIL hold_model: got %h expected %h", act, exp_vec(m_steps, m_ce));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    while (!(ce_pix && vcnt == 10'd1 && hcnt == 10'd3) && waited < 200) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited >= 200) begin
      $display("FAIL areset_find: got timeout expected v=1 h=3 pixel");
      return;
    end
    n_pass++;
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (act !== RESET_VEC) $display("FAIL areset_immediate: got %h expected %h", act, RESET_VEC);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (act !== RESET_VEC) $display("FAIL areset_held: got %h expected %h", act, RESET_VEC);
    else n_pass++;
    test_first_step();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (act !== exp_vec(m_steps, m_ce)) $display("FAIL areset_rerun: got %h expected %h", act, exp_vec(m_steps, m_ce));
      else n_pass++;
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (act !== exp_vec(m_steps, m_ce)) $display("FAIL rand_vec: got %h expected %h", act, exp_vec(m_steps, m_ce));
      else n_pass++;
    end
    enable = 1'b1;
  endtask

  task automatic test_default_line();
    int waited, t0, pix, hs_n, hs_first, hs_last;
    rst_def = 1'b1;
    @(negedge clk_vid);
    rst_def = 1'b0;
    waited = 0;
    while (!d_ls && waited < 100) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited >= 100) begin
      $display("FAIL def_first: got timeout expected line_start");
      return;
    end
    n_pass++;
    t0 = cyc; pix = 0; hs_n = 0; hs_first = -1; hs_last = -1; waited = 0;
    do begin
      if (d_ce) begin
        pix++;
        if (d_hs) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(d_hcnt);
          hs_last = int'(d_hcnt);
        end
      end
      tick();
      waited++;
    end while (!d_ls && waited < 3000);
    n_checks++;
    if (cyc - t0 !== 1408) $display("FAIL def_line_clocks: got %0d expected 1408", cyc - t0);
    else n_pass++;
    n_checks++;
    if (pix !== 352) $display("FAIL def_line_pixels: got %0d expected 352", pix);
    else n_pass++;
    n_checks++;
    if (hs_n !== 32 || hs_first !== 272 || hs_last !== 303)
      $display("FAIL def_hsync: got n=%0d %0d..%0d expected n=32 272..303", hs_n, hs_first, hs_last);
    else n_pass++;
  endtask

  task automatic test_default_frame();
    int waited, t0, lines, vs_first, vs_last, vb_first;
    rst_dv = 1'b1;
    @(negedge clk_vid);
    rst_dv = 1'b0;
    waited = 0;
    while (!v_fs && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited >= 20) begin
      $display("FAIL vdef_first: got timeout expected frame_start");
      return;
    end
    n_pass++;
    t0 = cyc; lines = 0; vs_first = -1; vs_last = -1; vb_first = -1; waited = 0;
    do begin
      if (v_ls) lines++;
      if (v_vs) begin
        if (vs_first < 0) vs_first = int'(v_vcnt);
        vs_last = int'(v_vcnt);
      end
      if (v_vb && vb_first < 0) vb_first = int'(v_vcnt);
      tick();
      waited++;
    end while (!v_fs && waited < 6000);
    n_checks++;
    if (cyc - t0 !== 262 * 16) $display("FAIL vdef_frame_clocks: got %0d expected %0d", cyc - t0, 262 * 16);
    else n_pass++;
    n_checks++;
    if (lines !== 262) $display("FAIL vdef_lines: got %0d expected 262", lines);
    else n_pass++;
    n_checks++;
    if (vs_first !== 232 || vs_last !== 235) $display("FAIL vdef_vsync: got %0d..%0d expected 232..235", vs_first, vs_last);
    else n_pass++;
    n_checks++;
    if (vb_first !== 224) $display("FAIL vdef_vblank: got %0d expected 224", vb_first);
    else n_pass++;
  endtask

  initial begin
    rst_def = 1'b1;
    rst_dv  = 1'b1;
    test_reset();
    test_first_step();
    test_line();
    test_frames();
    test_enable_hold();
    test_async_reset();
    test_random_enable();
    test_default_line();
    test_default_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing source that sits directly upstream of the scandoubler.
- Divides clk_vid into a single-cycle pixel enable and runs horizontal/vertical counters.
- Produces ce_pix, hs, vs, hb, vb in the form the scandoubler consumes: rising-edge ce_pix, active-high syncs and blanks.
- Exports the current pixel coordinates and line/frame start strobes so the LCD renderer can fetch pixel data in step.

Parameters:
CE_DIV, 4, clk_vid cycles per pixel; must be >= 2.
H_ACTIVE, 256, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 32, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels); must be >= 1
V_ACTIVE, 224, visible lines per frame
V_FP, 8, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 26, vertical back porch (lines); must be >= 1

Ports:
clk_vid  in  1  video clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run enable; low freezes all timing
ce_pix  out  1  one-cycle pixel enable
hs  out  1  horizontal sync, active high
vs  out  1  vertical sync, active high
hb  out  1  horizontal blank
vb  out  1  vertical blank
hcnt  out  10  current pixel column
vcnt  out  10  current line
line_start  out  1  pulses with the ce_pix on which hcnt becomes 0
frame_start  out  1  pulses with the ce_pix on which (hcnt,vcnt) becomes (0,0)

Behaviour:
- Derived values:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL likewise.
- Elaboration checks:
  - Error if H_TOTAL > 1024 or V_TOTAL > 1024.
  - Error if CE_DIV < 2.
  - Error if H_BP < 1 or V_BP < 1.
- Divider and pixel enable:
  - Divider width is $clog2(CE_DIV); counts 0..CE_DIV-1 and wraps to 0.
  - A pixel step occurs on the clock edge where the divider is CE_DIV-1 and enable is high.
  - On a pixel step, ce_pix is registered high for exactly one cycle. Otherwise ce_pix is 0.
- Register timing:
  - All outputs are registered.
  - On a pixel step, hcnt, vcnt, hs, vs, hb, vb, line_start and frame_start update on the same edge that raises ce_pix.
  - A consumer that samples while ce_pix is high therefore sees the timing for that pixel.
- Horizontal counter:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - On the wrap, vcnt increments; vcnt wraps from V_TOTAL-1 to 0.
- Decode, applied to the new counter values:
  - hb = hcnt >= H_ACTIVE.
  - hs = H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vb = vcnt >= V_ACTIVE.
  - vs = V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
- vs and vb change only on a step where hcnt becomes 0.
- line_start and frame_start are high only in the same cycle as ce_pix and are 0 otherwise.
- enable low:
  - Divider, counters and all level outputs hold.
  - ce_pix, line_start and frame_start are 0.
  - When enable returns high, the divider resumes from its held value, so no pixel is skipped or duplicated.
- Reset (asynchronous; takes effect without a clock edge):
  - divider=0.
  - hcnt=H_TOTAL-1, vcnt=V_TOTAL-1; the raster is parked on the last pixel.
  - hb=1, vb=1, hs=0, vs=0.
  - ce_pix=0, line_start=0, frame_start=0.
- First step after reset:
  - Occurs on the CE_DIV-th rising edge after release, given enable is high.
  - It produces (0,0) with frame_start=1, line_start=1, hb=0, vb=0.
- Reset asserted mid-operation abandons the current frame; there is no partial-line recovery.

Test Plan:
Bench parameters for scenarios 1-5: CE_DIV=2, H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6).
1. Release reset, enable=1 -> first ce_pix on edge 2 with hcnt=0, vcnt=0, frame_start=1, line_start=1, hb=0, vb=0; ce_pix then every 2 cycles, never two in a row.
2. Run one line -> hb=1 for hcnt 4..7; hs=1 for hcnt 5..6 only; line_start at each hcnt=0; line period 16 clocks.
3. Run two frames -> vb=1 for vcnt 3..5; vs=1 for vcnt 4 only; vs and vb toggle only with hcnt=0; vcnt 5->0 with frame_start; frame period 96 clocks.
4. Drop enable for 7 cycles at hcnt=2 -> no ce_pix and all outputs frozen; after re-enable, next ce_pix gives hcnt=3 with unchanged divider phase.
5. Assert reset asynchronously between edges at vcnt=1, hcnt=3 -> outputs immediately equal reset values; after release, scenario 1 sequence repeats.
6. Default parameters -> line = 352 pixels = 1408 clocks; hs high for hcnt 272..303; frame = 262 lines; vs high for vcnt 232..235.
